misr_sig: RTL and testbench
===========================

# misr_sig

Multiple-input signature register with session control. It sits directly downstream of the LFSR pattern generator in the BIST path. It compacts the circuit-under-test responses produced from each LFSR pattern into a WIDTH-bit signature. After NPAT accepted responses it compares the signature against a golden value and flags pass/fail.

## Interface
- WIDTH, 8: signature and response width (≥2).
- POLY, 8'hB8: feedback mask. Bit i (1..WIDTH-1) enables the feedback tap into stage i. The tap into stage 0 is implicit.
- SEED, 0: signature value loaded on start.
- NPAT, 255: number of responses per session (≥1).
- GOLDEN, 0: expected final signature.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin session (level-sampled).
- resp_valid  in  1  resp is valid this cycle.
- resp  in  WIDTH  CUT response word.
- busy  out  1  session running.
- done  out  1  session complete, held until next start.
- pass  out  1  final signature == GOLDEN. Valid only while done=1.
- signature  out  WIDTH  current MISR contents.
- pat_cnt  out  $clog2(NPAT+1)  responses accepted this session.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN; signature←SEED; pat_cnt←0.
  - resp and resp_valid are ignored.
- RUN:
  - On each edge with resp_valid=1, let s = signature and d = resp. The next value is:
    - next[0] = s[W-1] ^ d[0]
    - next[i] = s[i-1] ^ d[i] ^ (POLY[i] & s[W-1]) for i ≥ 1
  - pat_cnt increments on the same edge.
  - resp_valid=0: signature and pat_cnt hold.
  - start is ignored while in RUN.
- RUN→DONE on the edge that accepts the response with pat_cnt == NPAT-1. On that edge pat_cnt←NPAT and pass←(next signature == GOLDEN).
- DONE:
  - signature, pat_cnt and pass hold.
  - start=1 → RUN with the same reload as from IDLE. done and pass clear on that edge.
- Reset (async, any state, including mid-session) forces IDLE, signature=SEED, pat_cnt=0, busy=0, done=0, pass=0.
- pat_cnt never exceeds NPAT and never wraps.

## Timing
- All outputs are registered.
- busy=1 exactly while in RUN. done=1 exactly while in DONE.
- Start latency: start high at edge k → busy=1 after edge k. The first response can be accepted at edge k+1.
- Each response is accepted on the edge where busy & resp_valid. signature reflects it in the following cycle.
- Done latency: the edge that accepts the last response sets done=1, pass valid and busy=0 simultaneously. There is no extra cycle.
- Minimum session length is NPAT+1 edges from start, with resp_valid held high.
- start and resp_valid high together in IDLE: only the start is acted on; the response is dropped.

## Configuration
- MISR_SCAN_EN defined:
  - Adds ports scan_en (in, 1), scan_in (in, 1) and scan_out (out, 1).
  - While scan_en=1, in any state, the register shifts serially: signature←{signature[W-2:0], scan_in}.
  - scan_out = signature[W-1].
  - FSM, pat_cnt and compaction freeze while scan_en=1.
  - scan_en has priority over start and resp_valid.
- MISR_SCAN_EN not defined: the scan ports are absent and there is no scan logic.

## Structure
- Package misr_pkg holds:
  - the state enum (IDLE=0, RUN=1, DONE=2);
  - the default POLY and SEED constants;
  - a function computing the next MISR value from (s, d, poly).
- Sub-module misr_core: the WIDTH-bit register with load/compact/hold control and the scan shift, when enabled.
- misr_sig contains the FSM, the counter and the compare logic.

## Test plan
- Single-pattern walk: WIDTH=4, POLY=4'b0011, SEED=0, NPAT=5. Responses 1,0,0,0,0 → signature steps 1,2,4,8,3. done=1 after the fifth accept.
  - With GOLDEN=4'h3: pass=1.
  - With GOLDEN=4'h4: pass=0.
- Valid gaps: same as the single-pattern walk, but with resp_valid=0 cycles inserted between responses → identical final signature 4'h3. pat_cnt increments only on valid cycles.
- Start behaviour: start pulsed mid-RUN → ignored, pat_cnt continues. start in DONE → signature=SEED, pat_cnt=0, done=0, busy=1 on the next cycle.
- Reset mid-session: assert reset asynchronously after 3 accepts → outputs go immediately to IDLE values (busy=0, done=0, pass=0, signature=SEED, pat_cnt=0). A subsequent session completes correctly.
- Default parameters, all-zero responses: 255 accepts with resp=0 → signature=8'h00, pass=1, pat_cnt=255.
- MISR_SCAN_EN: load signature 4'h3, then scan_en=1 for 4 cycles with scan_in=1,0,1,0 →
  - scan_out sequence 0,0,1,1;
  - final signature 4'hA;
  - pat_cnt unchanged throughout.

Source files
------------

// File: rtl/misr_pkg.sv
// Shared MISR types, default constants and the compaction step function.
// Optional scan support lives in misr_core/misr_sig under MISR_SCAN_EN.
package misr_pkg;

    localparam int MISR_MAX_W = 64;

    localparam logic [7:0] MISR_DEFAULT_POLY = 8'hB8;
    localparam logic [7:0] MISR_DEFAULT_SEED = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } misr_state_e;

    // Operands are zero-extended to MISR_MAX_W; msbIdx selects the feedback stage
    // and the caller keeps only the low WIDTH bits of the result.
    function automatic logic [MISR_MAX_W-1:0] misrNext(
        input logic [MISR_MAX_W-1:0] s,
        input logic [MISR_MAX_W-1:0] d,
        input logic [MISR_MAX_W-1:0] poly,
        input logic [5:0]            msbIdx
    );
        logic msb;
        msb = s[msbIdx];
        return {s[MISR_MAX_W-2:0], 1'b0} ^ d ^
               ({poly[MISR_MAX_W-1:1], 1'b1} & {MISR_MAX_W{msb}});
    endfunction

endpackage

// File: rtl/misr_core.sv
// WIDTH-bit signature register with load / compact / hold control.
// With MISR_SCAN_EN defined the register also shifts serially while scan_en_i is high.
module misr_core
    import misr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_DEFAULT_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(MISR_DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             compact_i,
    input  logic [WIDTH-1:0] resp_i,
`ifdef MISR_SCAN_EN
    input  logic             scan_en_i,
    input  logic             scan_in_i,
`endif
    output logic [WIDTH-1:0] signature_o,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0]      sig_q;
    logic [WIDTH-1:0]      sig_d;
    logic [MISR_MAX_W-1:0] wideNext;
    logic                  unusedWideBits;

    assign wideNext = misrNext(MISR_MAX_W'(sig_q), MISR_MAX_W'(resp_i),
                               MISR_MAX_W'(POLY), 6'(WIDTH - 1));
    assign next_o         = wideNext[WIDTH-1:0];
    assign unusedWideBits = ^wideNext;

    // Later assignments take priority: scan shift over load over compaction.
    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = SEED;
        end else if (compact_i) begin
            sig_d = next_o;
        end
`ifdef MISR_SCAN_EN
        if (scan_en_i) begin
            sig_d = {sig_q[WIDTH-2:0], scan_in_i};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature_o = sig_q;

endmodule

// File: rtl/misr_sig.sv
// MISR session controller: IDLE/RUN/DONE FSM, response counter and golden compare.
// Define MISR_SCAN_EN to add the scan_en/scan_in/scan_out serial access ports.
module misr_sig
    import misr_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(MISR_DEFAULT_POLY),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(MISR_DEFAULT_SEED),
    parameter int               NPAT   = 255,
    parameter logic [WIDTH-1:0] GOLDEN = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        resp_valid,
    input  logic [WIDTH-1:0]            resp,
`ifdef MISR_SCAN_EN
    input  logic                        scan_en,
    input  logic                        scan_in,
    output logic                        scan_out,
`endif
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [WIDTH-1:0]            signature,
    output logic [$clog2(NPAT+1)-1:0]   pat_cnt
);

    localparam int                CNT_W    = $clog2(NPAT + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NPAT - 1);

    misr_state_e       state_q;
    misr_state_e       state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              pass_q;
    logic              pass_d;
    logic              busy_q;
    logic              done_q;
    logic              loadSig;
    logic              compactSig;
    logic              scanHold;
    logic [WIDTH-1:0]  nextSig;

`ifdef MISR_SCAN_EN
    assign scanHold = scan_en;
    assign scan_out = signature[WIDTH-1];
`else
    assign scanHold = 1'b0;
`endif

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .load_i      (loadSig),
        .compact_i   (compactSig),
        .resp_i      (resp),
`ifdef MISR_SCAN_EN
        .scan_en_i   (scan_en),
        .scan_in_i   (scan_in),
`endif
        .signature_o (signature),
        .next_o      (nextSig)
    );

    // A response arriving together with start in IDLE/DONE is dropped: only the reload happens.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        loadSig    = 1'b0;
        compactSig = 1'b0;
        if (!scanHold) begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        pass_d  = 1'b0;
                        loadSig = 1'b1;
                    end
                end
                RUN: begin
                    if (resp_valid) begin
                        compactSig = 1'b1;
                        cnt_d      = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_d = DONE;
                            pass_d  = (nextSig == GOLDEN);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign pat_cnt = cnt_q;

endmodule

// File: tb/tb_misr_sig.sv
// Scoreboard bench for misr_sig: two WIDTH=4 instances differing only in GOLDEN,
// plus one default-parameter instance. Scan checks are built when MISR_SCAN_EN is defined.
module tb_misr_sig;

    localparam logic [3:0] MPOLY = 4'b0011;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       respValid = 1'b0;
    logic [3:0] resp = 4'h0;
    logic       startC = 1'b0;
    logic       validC = 1'b0;
    logic [7:0] respC = 8'h00;
    logic       scanEn = 1'b0;
    logic       scanIn = 1'b0;
    logic       scanOff = 1'b0;

    logic       busyA, doneA, passA, scanOutA;
    logic [3:0] sigA;
    logic [2:0] cntA;
    logic       busyB, doneB, passB, unusedScanOutB;
    logic [3:0] sigB;
    logic [2:0] cntB;
    logic       busyC, doneC, passC, unusedScanOutC;
    logic [7:0] sigC;
    logic [7:0] cntC;

    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] expQ[$];
    logic [3:0] modelSig = 4'h0;
    int         modelCnt = 0;

    always #5 clk = ~clk;

    misr_sig #(.WIDTH(4), .POLY(MPOLY), .SEED(4'h0), .NPAT(5), .GOLDEN(4'h3)) dutA (
        .clk(clk), .reset(reset), .start(start), .resp_valid(respValid), .resp(resp),
`ifdef MISR_SCAN_EN
        .scan_en(scanEn), .scan_in(scanIn), .scan_out(scanOutA),
`endif
        .busy(busyA), .done(doneA), .pass(passA), .signature(sigA), .pat_cnt(cntA)
    );

    misr_sig #(.WIDTH(4), .POLY(MPOLY), .SEED(4'h0), .NPAT(5), .GOLDEN(4'h4)) dutB (
        .clk(clk), .reset(reset), .start(start), .resp_valid(respValid), .resp(resp),
`ifdef MISR_SCAN_EN
        .scan_en(scanOff), .scan_in(scanOff), .scan_out(unusedScanOutB),
`endif
        .busy(busyB), .done(doneB), .pass(passB), .signature(sigB), .pat_cnt(cntB)
    );

    misr_sig dutC (
        .clk(clk), .reset(reset), .start(startC), .resp_valid(validC), .resp(respC),
`ifdef MISR_SCAN_EN
        .scan_en(scanOff), .scan_in(scanOff), .scan_out(unusedScanOutC),
`endif
        .busy(busyC), .done(doneC), .pass(passC), .signature(sigC), .pat_cnt(cntC)
    );

`ifndef MISR_SCAN_EN
    assign scanOutA = 1'b0;
    assign unusedScanOutB = 1'b0;
    assign unusedScanOutC = 1'b0;
`endif

    // Bit-by-bit reference of one compaction step for WIDTH=4, POLY=4'b0011.
    function automatic logic [3:0] modelNext(input logic [3:0] s, input logic [3:0] d);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) r[i] = d[i] ^ s[3];
            else        r[i] = d[i] ^ s[i-1] ^ (MPOLY[i] & s[3]);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startSession();
        start = 1'b1;
        respValid = 1'b0;
        tick();
        start = 1'b0;
        modelSig = 4'h0;
        modelCnt = 0;
    endtask

    task automatic driveAccept(input logic [3:0] d);
        modelSig = modelNext(modelSig, d);
        modelCnt++;
        expQ.push_back(modelSig);
        resp = d;
        respValid = 1'b1;
        tick();
        respValid = 1'b0;
    endtask

    task automatic driveIdle();
        respValid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (busyA !== 1'b0 || doneA !== 1'b0 || passA !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got busy=%b done=%b pass=%b expected 0 0 0", busyA, doneA, passA);
        end
        vectors++;
        if (sigA !== 4'h0 || cntA !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state: got sig=%h cnt=%0d expected sig=0 cnt=0", sigA, cntA);
        end
        vectors++;
        if (sigC !== 8'h00 || cntC !== 8'd0 || busyC !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_default: got sig=%h cnt=%0d busy=%b expected 00 0 0", sigC, cntC, busyC);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_walk();
        logic [3:0] exp;
        logic [3:0] pattern [5] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        start = 1'b1;
        respValid = 1'b1;
        resp = 4'h5;
        tick();
        start = 1'b0;
        respValid = 1'b0;
        modelSig = 4'h0;
        modelCnt = 0;
        vectors++;
        if (busyA !== 1'b1 || sigA !== 4'h0 || cntA !== 3'd0 || doneA !== 1'b0) begin
            miscompares++;
            $display("FAIL walk_start: got busy=%b sig=%h cnt=%0d done=%b expected 1 0 0 0", busyA, sigA, cntA, doneA);
        end
        for (int i = 0; i < 5; i++) begin
            driveAccept(pattern[i]);
            exp = expQ.pop_front();
            vectors++;
            if (sigA !== exp || cntA !== 3'(modelCnt)) begin
                miscompares++;
                $display("FAIL walk_step[%0d]: got sig=%h cnt=%0d expected sig=%h cnt=%0d", i, sigA, cntA, exp, modelCnt);
            end
        end
        vectors++;
        if (sigA !== 4'h3 || doneA !== 1'b1 || busyA !== 1'b0 || passA !== 1'b1) begin
            miscompares++;
            $display("FAIL walk_done_A: got sig=%h done=%b busy=%b pass=%b expected 3 1 0 1", sigA, doneA, busyA, passA);
        end
        vectors++;
        if (sigB !== 4'h3 || doneB !== 1'b1 || busyB !== 1'b0 || passB !== 1'b0 || cntB !== 3'd5) begin
            miscompares++;
            $display("FAIL walk_done_B: got sig=%h done=%b busy=%b pass=%b cnt=%0d expected 3 1 0 0 5", sigB, doneB, busyB, passB, cntB);
        end
        resp = 4'hF;
        respValid = 1'b1;
        tick();
        respValid = 1'b0;
        vectors++;
        if (sigA !== 4'h3 || cntA !== 3'd5 || doneA !== 1'b1 || passA !== 1'b1) begin
            miscompares++;
            $display("FAIL walk_hold: got sig=%h cnt=%0d done=%b pass=%b expected 3 5 1 1", sigA, cntA, doneA, passA);
        end
    endtask

    task automatic test_gaps();
        logic [3:0] exp;
        logic [3:0] pattern [5] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        startSession();
        vectors++;
        if (sigA !== 4'h0 || cntA !== 3'd0 || doneA !== 1'b0 || busyA !== 1'b1 || passA !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_from_done: got sig=%h cnt=%0d done=%b busy=%b pass=%b expected 0 0 0 1 0", sigA, cntA, doneA, busyA, passA);
        end
        for (int i = 0; i < 5; i++) begin
            driveAccept(pattern[i]);
            exp = expQ.pop_front();
            vectors++;
            if (sigA !== exp) begin
                miscompares++;
                $display("FAIL gap_accept[%0d]: got sig=%h expected %h", i, sigA, exp);
            end
            driveIdle();
            driveIdle();
            vectors++;
            if (sigA !== modelSig || cntA !== 3'(modelCnt)) begin
                miscompares++;
                $display("FAIL gap_hold[%0d]: got sig=%h cnt=%0d expected sig=%h cnt=%0d", i, sigA, cntA, modelSig, modelCnt);
            end
        end
        vectors++;
        if (sigA !== 4'h3 || doneA !== 1'b1 || passA !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_final: got sig=%h done=%b pass=%b expected 3 1 1", sigA, doneA, passA);
        end
    endtask

    task automatic test_start_ignored();
        logic [3:0] exp;
        logic [3:0] pattern [5] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        startSession();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) start = 1'b1;
            driveAccept(pattern[i]);
            start = 1'b0;
            exp = expQ.pop_front();
            vectors++;
            if (sigA !== exp || cntA !== 3'(modelCnt)) begin
                miscompares++;
                $display("FAIL start_in_run[%0d]: got sig=%h cnt=%0d expected sig=%h cnt=%0d", i, sigA, cntA, exp, modelCnt);
            end
        end
        vectors++;
        if (doneA !== 1'b1 || passA !== 1'b1 || sigA !== 4'h3) begin
            miscompares++;
            $display("FAIL start_in_run_final: got done=%b pass=%b sig=%h expected 1 1 3", doneA, passA, sigA);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp;
        logic [3:0] pattern [5] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        startSession();
        for (int i = 0; i < 3; i++) begin
            driveAccept(pattern[i]);
            exp = expQ.pop_front();
            vectors++;
            if (sigA !== exp) begin
                miscompares++;
                $display("FAIL mid_accept[%0d]: got sig=%h expected %h", i, sigA, exp);
            end
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (busyA !== 1'b0 || doneA !== 1'b0 || passA !== 1'b0 || sigA !== 4'h0 || cntA !== 3'd0) begin
            miscompares++;
            $display("FAIL async_reset: got busy=%b done=%b pass=%b sig=%h cnt=%0d expected 0 0 0 0 0", busyA, doneA, passA, sigA, cntA);
        end
        #2 reset = 1'b0;
        tick();
        startSession();
        for (int i = 0; i < 5; i++) begin
            driveAccept(pattern[i]);
            exp = expQ.pop_front();
            vectors++;
            if (sigA !== exp) begin
                miscompares++;
                $display("FAIL post_reset[%0d]: got sig=%h expected %h", i, sigA, exp);
            end
        end
        vectors++;
        if (doneA !== 1'b1 || passA !== 1'b1 || cntA !== 3'd5 || passB !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_final: got done=%b passA=%b cnt=%0d passB=%b expected 1 1 5 0", doneA, passA, cntA, passB);
        end
    endtask

    task automatic test_default_zero();
        startC = 1'b1;
        tick();
        startC = 1'b0;
        respC = 8'h00;
        validC = 1'b1;
        repeat (254) tick();
        vectors++;
        if (busyC !== 1'b1 || cntC !== 8'd254 || doneC !== 1'b0) begin
            miscompares++;
            $display("FAIL default_254: got busy=%b cnt=%0d done=%b expected 1 254 0", busyC, cntC, doneC);
        end
        tick();
        vectors++;
        if (doneC !== 1'b1 || busyC !== 1'b0 || passC !== 1'b1 || sigC !== 8'h00 || cntC !== 8'd255) begin
            miscompares++;
            $display("FAIL default_done: got done=%b busy=%b pass=%b sig=%h cnt=%0d expected 1 0 1 00 255", doneC, busyC, passC, sigC, cntC);
        end
        tick();
        validC = 1'b0;
        vectors++;
        if (cntC !== 8'd255 || doneC !== 1'b1) begin
            miscompares++;
            $display("FAIL default_cnt_sat: got cnt=%0d done=%b expected 255 1", cntC, doneC);
        end
    endtask

`ifdef MISR_SCAN_EN
    task automatic test_scan();
        logic inBits [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic outBits [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        scanEn = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (scanOutA !== outBits[k]) begin
                miscompares++;
                $display("FAIL scan_out[%0d]: got %b expected %b", k, scanOutA, outBits[k]);
            end
            scanIn = inBits[k];
            tick();
            vectors++;
            if (cntA !== 3'd5 || doneA !== 1'b1) begin
                miscompares++;
                $display("FAIL scan_freeze[%0d]: got cnt=%0d done=%b expected 5 1", k, cntA, doneA);
            end
        end
        scanEn = 1'b0;
        start = 1'b0;
        vectors++;
        if (sigA !== 4'hA) begin
            miscompares++;
            $display("FAIL scan_final: got sig=%h expected a", sigA);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_walk();
        test_gaps();
        test_start_ignored();
        test_reset_mid();
        test_default_zero();
`ifdef MISR_SCAN_EN
        test_scan();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
